// File: rtl/tc_display_if.sv
// Requester-side bus of the display scheduler: level requests with packed data,
// and the scheduler's grant/ack/busy replies.
interface tc_display_if #(
  parameter int NUM_SRC = 4
);
  // req[i] is a level held by source i while data[4i+3:4i] is valid; data is
  // sampled only on the cycle grant[i] rises, and ack[i] pulses for one cycle
  // at the end of that source's dwell. Dropping req early never cancels a grant.
  logic [NUM_SRC-1:0]   req;
  logic [4*NUM_SRC-1:0] data;
  logic [NUM_SRC-1:0]   grant;
  logic [NUM_SRC-1:0]   ack;
  logic                 busy;

  modport master (output req, data, input grant, ack, busy);
  modport slave  (input req, data, output grant, ack, busy);
endinterface

// File: rtl/tc_display_scheduler.sv
// Round-robin scheduler sharing one two's-complement-to-7-segment converter
// between NUM_SRC requesters; each winner is shown on HEX1/HEX0 for DWELL cycles.
module tc_display_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 25000000,
  parameter int CW      = 25
) (
  input  logic        clk,
  input  logic        rst,
  tc_display_if.slave bus_if,
  output logic [3:0]  n_o,
  input  logic [6:0]  sign_in_i,
  input  logic [6:0]  mag_in_i,
  output logic [6:0]  hex1_o,
  output logic [6:0]  hex0_o,
  output logic [1:0]  dbg_state_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [3:0]         n_q, n_d;
  logic [6:0]         hex1_q, hex1_d;
  logic [6:0]         hex0_q, hex0_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      win_q, win_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand;

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand = IW'((int'(last_q) + i) % NUM_SRC);
      if (bus_if.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    n_d     = n_q;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          n_d               = bus_if.data[4*int'(pick_idx) +: 4];
          win_d             = pick_idx;
          state_d           = LOAD;
        end
      end
      LOAD: begin
        // Converter is combinational on n_q, so its outputs are settled here.
        hex1_d  = sign_in_i;
        hex0_d  = mag_in_i;
        cnt_d   = CW'(DWELL - 1);
        state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == '0) begin
          ack_d   = grant_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        ack_d   = '0;
        grant_d = '0;
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      n_q     <= '0;
      hex1_q  <= 7'b1111111;
      hex0_q  <= 7'b1111111;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_SRC - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      n_q     <= n_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign bus_if.grant = grant_q;
  assign bus_if.ack   = ack_q;
  assign bus_if.busy  = (state_q != IDLE);
  assign n_o          = n_q;
  assign hex1_o       = hex1_q;
  assign hex0_o       = hex0_q;
  assign dbg_state_o  = state_q;

endmodule
